// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the execute load/store path.
// Data side has priority; a starvation counter forces a fetch grant after repeated data grants.
module memory_port_arbiter #(
   parameter int unsigned ADDRESS_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned STARVATION_LIMIT = 4,
   parameter int unsigned TIMEOUT_CYCLES   = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      fetch_request,
   input  logic [ADDRESS_WIDTH-1:0]  fetch_address,
   output logic [DATA_WIDTH-1:0]     fetch_read_value,
   output logic                      fetch_valid,
   output logic                      fetch_error,
   input  logic                      data_request,
   input  logic                      data_write,
   input  logic [ADDRESS_WIDTH-1:0]  data_address,
   input  logic [DATA_WIDTH-1:0]     data_write_value,
   input  logic [DATA_WIDTH/8-1:0]   data_byte_mask,
   output logic [DATA_WIDTH-1:0]     data_read_value,
   output logic                      data_valid,
   output logic                      data_error,
   output logic                      memory_read_enable,
   output logic                      memory_write_enable,
   output logic [ADDRESS_WIDTH-1:0]  memory_address,
   output logic [DATA_WIDTH-1:0]     memory_write_value,
   output logic [DATA_WIDTH/8-1:0]   memory_byte_mask,
   input  logic [DATA_WIDTH-1:0]     memory_read_value,
   input  logic                      memory_ready,
   output logic                      busy
);

   localparam int unsigned TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned STARVE_WIDTH = $clog2(STARVATION_LIMIT + 1);
   localparam logic [TIMER_WIDTH-1:0]  TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVATION_LIMIT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]              state;
   logic                    winner_fetch;
   logic [TIMER_WIDTH-1:0]  timeout_count;
   logic [STARVE_WIDTH-1:0] starve_count;
   logic                    grant;
   logic                    pick_fetch;

   always_comb begin
      grant      = enable && (fetch_request || data_request);
      pick_fetch = fetch_request && (!data_request || (starve_count >= STARVE_MAX));
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         winner_fetch        <= 1'b0;
         timeout_count       <= '0;
         starve_count        <= '0;
         memory_read_enable  <= 1'b0;
         memory_write_enable <= 1'b0;
         memory_address      <= '0;
         memory_write_value  <= '0;
         memory_byte_mask    <= '0;
         fetch_read_value    <= '0;
         fetch_valid         <= 1'b0;
         fetch_error         <= 1'b0;
         data_read_value     <= '0;
         data_valid          <= 1'b0;
         data_error          <= 1'b0;
      end else begin
         fetch_valid <= 1'b0;
         fetch_error <= 1'b0;
         data_valid  <= 1'b0;
         data_error  <= 1'b0;
         case (state)
            IDLE: begin
               if (!fetch_request) starve_count <= '0;
               if (grant) begin
                  state         <= ACCESS;
                  winner_fetch  <= pick_fetch;
                  timeout_count <= '0;
                  if (pick_fetch) begin
                     starve_count        <= '0;
                     memory_address      <= fetch_address;
                     memory_read_enable  <= 1'b1;
                     memory_write_enable <= 1'b0;
                     memory_write_value  <= '0;
                     memory_byte_mask    <= '1;
                  end else begin
                     if (fetch_request && (starve_count < STARVE_MAX))
                        starve_count <= starve_count + STARVE_WIDTH'(1);
                     memory_address      <= data_address;
                     memory_read_enable  <= !data_write;
                     memory_write_enable <= data_write;
                     memory_write_value  <= data_write_value;
                     memory_byte_mask    <= data_byte_mask;
                  end
               end
            end
            ACCESS: begin
               // Valid/error registers are set on the way into DONE so they are high exactly in DONE.
               if (memory_ready || (timeout_count == TIMER_LAST)) begin
                  state               <= DONE;
                  memory_read_enable  <= 1'b0;
                  memory_write_enable <= 1'b0;
                  if (winner_fetch) begin
                     fetch_valid <= 1'b1;
                     fetch_error <= !memory_ready;
                  end else begin
                     data_valid <= 1'b1;
                     data_error <= !memory_ready;
                  end
                  if (!memory_ready) begin
                     if (winner_fetch) fetch_read_value <= '0;
                     else              data_read_value  <= '0;
                  end else if (memory_read_enable) begin
                     if (winner_fetch) fetch_read_value <= memory_read_value;
                     else              data_read_value  <= memory_read_value;
                  end
               end else begin
                  timeout_count <= timeout_count + TIMER_WIDTH'(1);
               end
            end
            DONE: begin
               state         <= IDLE;
               timeout_count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
